bsg_reset_sequencer: RTL
========================

# bsg_reset_sequencer

Parametrised single-clock reset sequencer generating `els_p` ordered reset outputs with per-channel programmable release delays. It starts a full sequence automatically after power-on, and restarts on request. A request typically comes from a `bsg_tag_client` `recv_new_r_o` pulse resynchronised into `clk_i`. `resets_o` bits feed per-domain `bsg_sync_sync` stages or domain resets.

## Interface
Parameters:
- `els_p`, 4 — number of reset channels (≥1)
- `delay_width_p`, 8 — width of each per-channel delay field
- `assert_cycles_p`, 16 — cycles all resets are held asserted before the first release (≥1)

Ports:
- `clk_i`  in  1  — sole clock
- `reset_n_i`  in  1  — asynchronous, active-low reset
- `req_v_i`  in  1  — request a new full reset sequence
- `req_ready_o`  out  1  — request accepted this cycle if `req_v_i` is also high
- `delays_i`  in  `els_p*delay_width_p`  — field i = extra hold cycles before releasing channel i
- `resets_o`  out  `els_p`  — active-high resets; bit i released in ascending i order
- `done_o`  out  1  — all channels released, sequence complete

## Operation
- States: `eAssert`, `eRelease`, `eDone`.
- Async reset, while `reset_n_i` is low:
  - `resets_o` = all 1s, `done_o` = 0, `req_ready_o` = 0.
  - state = `eAssert`, `cnt` = `assert_cycles_p`-1, `idx` = 0.
- `eAssert`:
  - All resets held high; `cnt` decrements each cycle.
  - When `cnt`==0: go to `eRelease`, load `cnt` ← `delays_i[0]`, `idx` ← 0.
- `eRelease`:
  - `cnt`≠0: decrement.
  - `cnt`==0: clear `resets_o[idx]`.
    - If `idx`==`els_p`-1: go to `eDone` and set `done_o`.
    - Otherwise: `idx`++, load `cnt` ← `delays_i[idx+1]`.
- `eDone`:
  - `done_o`=1, `req_ready_o`=1 (combinational from state).
  - On `req_v_i`: go to `eAssert`, set all `resets_o`, clear `done_o`, `cnt` ← `assert_cycles_p`-1, `idx` ← 0.
- `req_v_i` outside `eDone` is ignored (`req_ready_o`=0); requests are not queued.
- Delay fields are sampled only at stage load. Changing `delays_i` mid-sequence affects only channels not yet loaded.
- Delay 0 is legal: the channel releases one cycle after its stage is entered.
- Released bits stay low until the next accepted request or reset; no bit re-asserts individually.
- Counter width = max(`delay_width_p`, `$clog2(assert_cycles_p)`); no wrap, since loaded values always fit.

## Timing
- All outputs except `req_ready_o` are registered.
- `eAssert` lasts exactly `assert_cycles_p` cycles.
- `resets_o[0]` falls `assert_cycles_p` + d0 + 1 cycles after `eAssert` is entered.
- `resets_o[i]` falls d_i + 1 cycles after `resets_o[i-1]`.
- `done_o` rises on the same edge `resets_o[els_p-1]` falls.
- Full sequence length = `assert_cycles_p` + Σ(d_i + 1) cycles.
- Accepted request: all `resets_o` high and `done_o` low on the next edge.
- `reset_n_i` asserted mid-sequence: outputs return to reset values immediately, asynchronously.
- After `reset_n_i` deasserts, the sequence starts from `eAssert` with no request needed.
- `req_v_i` held high continuously in `eDone`: accepted once; it can be accepted again only after the next `done_o`.

## Structure
- `bsg_reset_seq_pkg`: state enum `bsg_reset_seq_state_e`, plus a helper function computing counter width.
- One sub-module, `bsg_reset_seq_down_ctr`: loadable down-counter with async active-low clear and a zero flag; width is a parameter.
- The top level holds the FSM, `idx`, and the `resets_o` / `done_o` registers.
- Delay field select is an indexed slice of `delays_i`.

## Test plan
- **Power-on**: `els_p`=4, `assert_cycles_p`=16, delays={0,3,1,7}.
  - `resets_o[0..3]` fall at cycles 17, 21, 23, 31.
  - `done_o`=1 at cycle 31.
- **Restart**: `req_v_i` pulse in `eDone`.
  - Next cycle: `resets_o`=4'b1111, `done_o`=0.
  - The identical schedule replays relative to the accept cycle.
- **Ignored request**: `req_v_i` high during `eRelease`.
  - `req_ready_o`=0; schedule unchanged.
  - A request held continuously is accepted exactly once, at `done_o`.
- **Async abort**: `reset_n_i` low at cycle 22, with channels 0 and 1 released.
  - `resets_o`=4'b1111 without a clock edge.
  - After release, full schedule from cycle 0.
- **Delay corner cases**:
  - Delays all 255: channel 3 falls at 16 + 4×256 = 1040.
  - Changing `delays_i[3]` from 7 to 2 while channel 1 is pending: channel 3 falls 3 cycles after channel 2.

Source files
------------

// File: rtl/bsg_reset_seq_pkg.sv
// Shared types and helpers for the ordered reset sequencer.
package bsg_reset_seq_pkg;

  typedef enum logic [1:0] {
    eAssert  = 2'd0,
    eRelease = 2'd1,
    eDone    = 2'd2
  } bsg_reset_seq_state_e;

  // The counter must hold both the widest delay field and assert_cycles-1.
  function automatic int unsigned bsg_reset_seq_ctr_width(input int unsigned delay_width,
                                                          input int unsigned assert_cycles);
    int unsigned assert_w;
    assert_w = $clog2(assert_cycles);
    return (delay_width > assert_w) ? delay_width : assert_w;
  endfunction

endpackage

// File: rtl/bsg_reset_seq_down_ctr.sv
// Loadable down-counter with async active-low clear to a parameterised value.
// It stops at zero and reports zero through zero_o.
module bsg_reset_seq_down_ctr #(
  parameter int unsigned           width_p     = 8,
  parameter logic [width_p-1:0]    reset_val_p = {width_p{1'b0}}
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               load_i,
  input  logic [width_p-1:0] load_val_i,
  input  logic               dec_i,
  output logic               zero_o
);

  logic [width_p-1:0] cnt_q, cnt_d;

  assign zero_o = (cnt_q == {width_p{1'b0}});

  // load wins over decrement; the count never wraps below zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && !zero_o) begin
      cnt_d = cnt_q - width_p'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q <= reset_val_p;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bsg_reset_sequencer.sv
// Ordered reset sequencer: holds all resets for assert_cycles_p cycles, then
// releases channel i after delays_i field i + 1 cycles, in ascending order.
module bsg_reset_sequencer
  import bsg_reset_seq_pkg::*;
#(
  parameter int unsigned els_p           = 4,
  parameter int unsigned delay_width_p   = 8,
  parameter int unsigned assert_cycles_p = 16
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic                             req_v_i,
  output logic                             req_ready_o,
  input  logic [els_p*delay_width_p-1:0]   delays_i,
  output logic [els_p-1:0]                 resets_o,
  output logic                             done_o
);

  localparam int unsigned ctr_w_lp = bsg_reset_seq_ctr_width(delay_width_p, assert_cycles_p);
  localparam int unsigned idx_w_lp = (els_p > 32'd1) ? $clog2(els_p) : 32'd1;
  localparam int unsigned sel_w_lp = (els_p * delay_width_p > 32'd1)
                                     ? $clog2(els_p * delay_width_p) : 32'd1;
  localparam logic [idx_w_lp-1:0] last_idx_lp   = idx_w_lp'(els_p - 32'd1);
  localparam logic [ctr_w_lp-1:0] assert_val_lp = ctr_w_lp'(assert_cycles_p - 32'd1);

  bsg_reset_seq_state_e state_q, state_d;
  logic [idx_w_lp-1:0]  idx_q, idx_d;
  logic [els_p-1:0]     resets_q, resets_d;
  logic                 done_q, done_d;

  logic                     ctr_load_s;
  logic                     ctr_dec_s;
  logic [ctr_w_lp-1:0]      ctr_load_val_s;
  logic                     ctr_zero_s;
  logic [idx_w_lp-1:0]      dly_sel_s;
  logic [sel_w_lp-1:0]      dly_base_s;
  logic [delay_width_p-1:0] dly_field_s;

  // Field 0 is loaded on leaving eAssert; otherwise the next channel's field.
  assign dly_sel_s   = (state_q == eRelease && idx_q != last_idx_lp)
                       ? idx_q + idx_w_lp'(1'b1) : {idx_w_lp{1'b0}};
  assign dly_base_s  = sel_w_lp'(dly_sel_s) * sel_w_lp'(delay_width_p);
  assign dly_field_s = delays_i[dly_base_s +: delay_width_p];

  bsg_reset_seq_down_ctr #(
    .width_p     (ctr_w_lp),
    .reset_val_p (assert_val_lp)
  ) u_ctr (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .load_i     (ctr_load_s),
    .load_val_i (ctr_load_val_s),
    .dec_i      (ctr_dec_s),
    .zero_o     (ctr_zero_s)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= eAssert;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      eAssert: begin
        if (ctr_zero_s) state_d = eRelease;
        else            state_d = eAssert;
      end
      eRelease: begin
        if (ctr_zero_s && idx_q == last_idx_lp) state_d = eDone;
        else                                    state_d = eRelease;
      end
      eDone: begin
        if (req_v_i) state_d = eAssert;
        else         state_d = eDone;
      end
      default: state_d = eAssert;
    endcase
  end

  // Counter control plus next values of idx and the registered outputs
  always_comb begin
    idx_d          = idx_q;
    resets_d       = resets_q;
    done_d         = done_q;
    ctr_load_s     = 1'b0;
    ctr_dec_s      = 1'b0;
    ctr_load_val_s = ctr_w_lp'(dly_field_s);
    case (state_q)
      eAssert: begin
        idx_d = {idx_w_lp{1'b0}};
        if (ctr_zero_s) begin
          ctr_load_s = 1'b1;
        end else begin
          ctr_dec_s = 1'b1;
        end
      end
      eRelease: begin
        if (ctr_zero_s) begin
          resets_d[idx_q] = 1'b0;
          if (idx_q == last_idx_lp) begin
            done_d = 1'b1;
          end else begin
            idx_d      = idx_q + idx_w_lp'(1'b1);
            ctr_load_s = 1'b1;
          end
        end else begin
          ctr_dec_s = 1'b1;
        end
      end
      eDone: begin
        if (req_v_i) begin
          resets_d       = {els_p{1'b1}};
          done_d         = 1'b0;
          idx_d          = {idx_w_lp{1'b0}};
          ctr_load_s     = 1'b1;
          ctr_load_val_s = assert_val_lp;
        end else begin
          done_d = 1'b1;
        end
      end
      default: begin
        resets_d       = {els_p{1'b1}};
        done_d         = 1'b0;
        idx_d          = {idx_w_lp{1'b0}};
        ctr_load_s     = 1'b1;
        ctr_load_val_s = assert_val_lp;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      idx_q    <= {idx_w_lp{1'b0}};
      resets_q <= {els_p{1'b1}};
      done_q   <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      resets_q <= resets_d;
      done_q   <= done_d;
    end
  end

  assign resets_o    = resets_q;
  assign done_o      = done_q;
  assign req_ready_o = (state_q == eDone);

endmodule
